hazard_forward_unit: RTL and testbench

- Parametrised hazard/forwarding unit for the pipelined MIPS core. It generates the stall and forward-A/B controls that the decode-stage control unit leaves unimplemented.
- It keeps a scoreboard shift pipeline of in-flight register writers for the stages after ID (EX, MEM, WB, ...) and resolves RAW hazards.
- Stall sources: load-use hazards and multi-cycle EX operations.
- Sits beside the control unit. Consumes decoded ID-stage fields; drives stall to the PC/IF-ID registers and forward selects to the ID-stage operand muxes.

---
 rtl/hazard_forward_unit.sv | 123 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit: tracks in-flight register writers after ID and
// resolves RAW hazards via forward selects, load-use and multi-cycle stalls.
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int PIPE_DEPTH       = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int MULTI_LATENCY    = 4,
    parameter int FWD_WIDTH        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      idValid,
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic                      idUsesRs,
    input  logic                      idUsesRt,
    input  logic                      idWritesReg,
    input  logic [REG_ADDR_WIDTH-1:0] idDestReg,
    input  logic                      idIsLoad,
    input  logic                      idIsMulti,
    input  logic                      flush,
    output logic                      shouldStall,
    output logic [FWD_WIDTH-1:0]      forwardSelectA,
    output logic [FWD_WIDTH-1:0]      forwardSelectB,
    output logic                      multiBusy
);

    localparam int CNT_WIDTH = $clog2(MULTI_LATENCY);

    logic [PIPE_DEPTH-1:0]     r_valid;
    logic [PIPE_DEPTH-1:0]     r_is_load;
    logic [REG_ADDR_WIDTH-1:0] r_dest [PIPE_DEPTH];
    logic [CNT_WIDTH-1:0]      r_count;

    logic                 w_use_a;
    logic                 w_use_b;
    logic [FWD_WIDTH-1:0] w_sel_a;
    logic [FWD_WIDTH-1:0] w_sel_b;
    logic                 w_load_a;
    logic                 w_load_b;
    logic                 w_multi_busy;
    logic                 w_multi_haz;
    logic                 w_stall;
    logic                 w_accept;

    assign w_use_a = idUsesRs && (idRs != '0);
    assign w_use_b = idUsesRt && (idRt != '0);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_load_a = 1'b0;
        w_load_b = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (w_use_a && r_valid[k] && (r_dest[k] == idRs)) begin
                w_sel_a  = FWD_WIDTH'(k + 1);
                w_load_a = r_is_load[k] && (k < LOAD_READY_STAGE);
            end
            if (w_use_b && r_valid[k] && (r_dest[k] == idRt)) begin
                w_sel_b  = FWD_WIDTH'(k + 1);
                w_load_b = r_is_load[k] && (k < LOAD_READY_STAGE);
            end
        end
    end

    assign w_multi_busy = (r_count != '0);
    assign w_multi_haz  = w_multi_busy &&
                          (idIsMulti ||
                           (r_valid[0] && ((w_use_a && (idRs == r_dest[0])) ||
                                           (w_use_b && (idRt == r_dest[0])))));
    assign w_stall      = idValid && !flush && (w_load_a || w_load_b || w_multi_haz);
    assign w_accept     = idValid && !flush && !w_stall;

    assign shouldStall    = w_stall;
    assign forwardSelectA = w_sel_a;
    assign forwardSelectB = w_sel_b;
    assign multiBusy      = w_multi_busy;

    // EX (entry 0) holds while a multi-cycle op occupies it; entry 1 gets a bubble.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_valid[1:0]   <= '0;
            r_is_load[1:0] <= '0;
            r_dest[0]      <= '0;
            r_dest[1]      <= '0;
            r_count        <= '0;
        end else if (w_multi_busy) begin
            r_valid[1]   <= 1'b0;
            r_is_load[1] <= 1'b0;
            r_dest[1]    <= r_dest[0];
            r_count      <= r_count - 1'b1;
        end else begin
            r_valid[0]   <= w_accept && idWritesReg;
            r_is_load[0] <= w_accept && idWritesReg && idIsLoad;
            r_dest[0]    <= idDestReg;
            r_valid[1]   <= r_valid[0];
            r_is_load[1] <= r_is_load[0];
            r_dest[1]    <= r_dest[0];
            if (w_accept && idIsMulti) begin
                r_count <= CNT_WIDTH'(MULTI_LATENCY - 1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 2; gi < PIPE_DEPTH; gi++) begin : g_shift
            always_ff @(posedge clock or negedge resetN) begin
                if (!resetN) begin
                    r_valid[gi]   <= 1'b0;
                    r_is_load[gi] <= 1'b0;
                    r_dest[gi]    <= '0;
                end else begin
                    r_valid[gi]   <= r_valid[gi-1];
                    r_is_load[gi] <= r_is_load[gi-1];
                    r_dest[gi]    <= r_dest[gi-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: hand-computed stall/forward/busy
// expectations for ALU chains, load-use, $0, multi-cycle ops, flush and reset.
module tb_hazard_forward_unit;

    logic       clock;
    logic       resetN;
    logic       idValid;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUsesRs;
    logic       idUsesRt;
    logic       idWritesReg;
    logic [4:0] idDestReg;
    logic       idIsLoad;
    logic       idIsMulti;
    logic       flush;
    logic       shouldStall;
    logic [1:0] forwardSelectA;
    logic [1:0] forwardSelectB;
    logic       multiBusy;

    int total_cnt;
    int bad_cnt;

    hazard_forward_unit #(
        .REG_ADDR_WIDTH  (5),
        .PIPE_DEPTH      (3),
        .LOAD_READY_STAGE(1),
        .MULTI_LATENCY   (4)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .idValid       (idValid),
        .idRs          (idRs),
        .idRt          (idRt),
        .idUsesRs      (idUsesRs),
        .idUsesRt      (idUsesRt),
        .idWritesReg   (idWritesReg),
        .idDestReg     (idDestReg),
        .idIsLoad      (idIsLoad),
        .idIsMulti     (idIsMulti),
        .flush         (flush),
        .shouldStall   (shouldStall),
        .forwardSelectA(forwardSelectA),
        .forwardSelectB(forwardSelectB),
        .multiBusy     (multiBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_id(input string name, input logic v, input logic [4:0] rs,
                            input logic [4:0] rt, input logic urs, input logic urt,
                            input logic wr, input logic [4:0] dst, input logic ld,
                            input logic mul, input logic fl);
        idValid     = v;
        idRs        = rs;
        idRt        = rt;
        idUsesRs    = urs;
        idUsesRt    = urt;
        idWritesReg = wr;
        idDestReg   = dst;
        idIsLoad    = ld;
        idIsMulti   = mul;
        flush       = fl;
        $display("t=%0t id: %s", $time, name);
    endtask

    task automatic idle();
        drive_id("idle", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic st, input logic [1:0] fa,
                              input logic [1:0] fb, input logic mb);
        @(negedge clock);
        check_val({tag, ".stall"}, 32'(shouldStall), 32'(st));
        check_val({tag, ".fwdA"},  32'(forwardSelectA), 32'(fa));
        check_val({tag, ".fwdB"},  32'(forwardSelectB), 32'(fb));
        check_val({tag, ".busy"},  32'(multiBusy), 32'(mb));
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        resetN    = 1'b0;
        idle();
        #2;
        check_val("rst.stall", 32'(shouldStall), 32'd0);
        check_val("rst.fwdA", 32'(forwardSelectA), 32'd0);
        check_val("rst.fwdB", 32'(forwardSelectB), 32'd0);
        check_val("rst.busy", 32'(multiBusy), 32'd0);
        #11 resetN = 1'b1;
        next_cycle();

        // ALU chain: add $3,$1,$2 ; sub $4,$3,$5 ; or $7,$3,$0
        drive_id("add $3,$1,$2", 1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0);
        expect_out("alu0", 0, 2'd0, 2'd0, 0);
        next_cycle();
        drive_id("sub $4,$3,$5", 1, 5'd3, 5'd5, 1, 1, 1, 5'd4, 0, 0, 0);
        expect_out("alu1", 0, 2'd1, 2'd0, 0);
        next_cycle();
        drive_id("or $7,$3,$0", 1, 5'd3, 5'd0, 1, 1, 1, 5'd7, 0, 0, 0);
        expect_out("alu2", 0, 2'd2, 2'd0, 0);
        next_cycle();
        idle(); next_cycle(); next_cycle(); next_cycle();

        // Load-use: lw $8,0($9) ; add $10,$8,$8
        drive_id("lw $8,0($9)", 1, 5'd9, 5'd0, 1, 0, 1, 5'd8, 1, 0, 0);
        expect_out("lw0", 0, 2'd0, 2'd0, 0);
        next_cycle();
        drive_id("add $10,$8,$8", 1, 5'd8, 5'd8, 1, 1, 1, 5'd10, 0, 0, 0);
        expect_out("lu1", 1, 2'd1, 2'd1, 0);
        next_cycle();
        expect_out("lu2", 0, 2'd2, 2'd2, 0);
        next_cycle();
        idle(); next_cycle(); next_cycle(); next_cycle();

        // Register 0 never forwards
        drive_id("addi $0,$0,5", 1, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0);
        next_cycle();
        drive_id("add $12,$0,$0", 1, 5'd0, 5'd0, 1, 1, 1, 5'd12, 0, 0, 0);
        expect_out("r0", 0, 2'd0, 2'd0, 0);
        next_cycle();
        idle(); next_cycle(); next_cycle(); next_cycle();

        // Multi-cycle op to $6, then dependent reader: 3 stalled cycles
        drive_id("mul $6,$1,$2", 1, 5'd1, 5'd2, 1, 1, 1, 5'd6, 0, 1, 0);
        expect_out("mul0", 0, 2'd0, 2'd0, 0);
        next_cycle();
        drive_id("add $11,$6,$1", 1, 5'd6, 5'd1, 1, 1, 1, 5'd11, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("mul_busy%0d", i), 1, 2'd1, 2'd0, 1);
            next_cycle();
        end
        expect_out("mul_done", 0, 2'd1, 2'd0, 0);
        next_cycle();
        idle(); next_cycle(); next_cycle(); next_cycle();

        // Flush during a multi op kills the reader but the op keeps running
        drive_id("mul $6,$1,$2", 1, 5'd1, 5'd2, 1, 1, 1, 5'd6, 0, 1, 0);
        next_cycle();
        drive_id("add $11,$6,$1 flushed", 1, 5'd6, 5'd1, 1, 1, 1, 5'd11, 0, 0, 1);
        expect_out("mulfl", 0, 2'd1, 2'd0, 1);
        next_cycle();
        drive_id("add $11,$6,$1", 1, 5'd6, 5'd1, 1, 1, 1, 5'd11, 0, 0, 0);
        expect_out("mulfl2", 1, 2'd1, 2'd0, 1);
        next_cycle();
        idle(); next_cycle(); next_cycle(); next_cycle(); next_cycle();

        // Flushed load-use reader: no stall, a bubble enters EX
        drive_id("lw $8,0($9)", 1, 5'd9, 5'd0, 1, 0, 1, 5'd8, 1, 0, 0);
        next_cycle();
        drive_id("add $10,$8,$8 flushed", 1, 5'd8, 5'd8, 1, 1, 1, 5'd10, 0, 0, 1);
        expect_out("fl1", 0, 2'd1, 2'd1, 0);
        next_cycle();
        drive_id("add $13,$10,$8", 1, 5'd10, 5'd8, 1, 1, 1, 5'd13, 0, 0, 0);
        expect_out("fl2", 0, 2'd0, 2'd2, 0);
        next_cycle();
        idle(); next_cycle(); next_cycle(); next_cycle();

        // Reset asserted mid-multi clears everything at once
        drive_id("mul $6,$1,$2", 1, 5'd1, 5'd2, 1, 1, 1, 5'd6, 0, 1, 0);
        next_cycle();
        drive_id("add $11,$6,$1", 1, 5'd6, 5'd1, 1, 1, 1, 5'd11, 0, 0, 0);
        #1;
        check_val("prerst.busy", 32'(multiBusy), 32'd1);
        resetN = 1'b0;
        #1;
        check_val("midrst.busy", 32'(multiBusy), 32'd0);
        check_val("midrst.stall", 32'(shouldStall), 32'd0);
        check_val("midrst.fwdA", 32'(forwardSelectA), 32'd0);
        check_val("midrst.fwdB", 32'(forwardSelectB), 32'd0);
        #1 resetN = 1'b1;
        expect_out("postrst", 0, 2'd0, 2'd0, 0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
